kmeans_assign_ctrl: RTL

- Sequences the assignment step of the k-means engine.
- Accepts one point at a time and scans the active centroids one per cycle from the centroid store.
- Computes the squared Euclidean distance of each centroid to the point and tracks the running minimum.
- Emits the index and distance of the nearest centroid on a valid/ready result port.
- Sits between the point stream and the centroid-update accumulator; time-shares a single distance lane instead of a full 2**N-wide array.

---
 rtl/kmeans_assign_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/kmeans_assign_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kmeans_assign_ctrl: nearest-centroid search for one point over a single
// time-shared squared-distance lane.                           Rev 1.0
// ----------------------------------------------------------------------------
module kmeans_assign_ctrl #(
  parameter int N = 8,
  parameter int D = 2,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N:0]     k_count,
  input  logic           pt_valid,
  output logic           pt_ready,
  input  logic [D*W-1:0] pt_data,
  output logic           cent_rd,
  output logic [N-1:0]   cent_addr,
  input  logic [D*W-1:0] cent_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_idx,
  output logic [W-1:0]   res_dist,
  output logic [W-1:0]   pts_done,
  output logic           busy
);

  localparam logic [N:0] c_one  = {{N{1'b0}}, 1'b1};
  localparam logic [N:0] c_kmax = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state, w_next;
  logic           r_pt_ready, r_res_valid, r_first;
  logic [D*W-1:0] r_pt;
  logic [N:0]     r_k, w_k_clamp;
  logic [N-1:0]   r_addr, r_min_idx, r_res_idx, w_cmp_idx, w_new_idx;
  logic [W-1:0]   r_min_dist, r_res_dist, r_pts_done, w_dist, w_diff, w_new_dist;
  logic           w_accept, w_handoff, w_last, w_cmp_en, w_take;

  assign w_accept  = (r_state == S_IDLE) && pt_valid && r_pt_ready;
  assign w_handoff = (r_state == S_DONE) && r_res_valid && res_ready;
  assign w_last    = ({1'b0, r_addr} == (r_k - c_one));
  assign w_k_clamp = (k_count == '0) ? c_one :
                     (k_count > c_kmax) ? c_kmax : k_count;

  // cent_data lags the strobe by one cycle; in FLUSH the address holds at K-1
  assign w_cmp_idx = (r_state == S_FLUSH) ? r_addr : (r_addr - N'(1));
  assign w_cmp_en  = ((r_state == S_SCAN) && !r_first) || (r_state == S_FLUSH);

  always_comb begin
    w_dist = '0;
    w_diff = '0;
    for (int j = 0; j < D; j++) begin
      w_diff = cent_data[j*W +: W] - r_pt[j*W +: W];
      w_dist = w_dist + w_diff * w_diff;
    end
  end

  // centroid 0 must win even if its distance equals the all-ones seed
  assign w_take     = w_cmp_en && ((w_cmp_idx == '0) || (w_dist < r_min_dist));
  assign w_new_dist = w_take ? w_dist : r_min_dist;
  assign w_new_idx  = w_take ? w_cmp_idx : r_min_idx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  if (w_handoff) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pt_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_first     <= 1'b0;
      r_pt        <= '0;
      r_k         <= c_one;
      r_addr      <= '0;
      r_min_idx   <= '0;
      r_min_dist  <= '0;
      r_res_idx   <= '0;
      r_res_dist  <= '0;
      r_pts_done  <= '0;
    end else begin
      r_state     <= w_next;
      r_pt_ready  <= (w_next == S_IDLE);
      r_res_valid <= (r_state == S_DONE) && (w_next == S_DONE);
      if (w_accept) begin
        r_pt       <= pt_data;
        r_k        <= w_k_clamp;
        r_min_dist <= '1;
        r_min_idx  <= '0;
        r_addr     <= '0;
        r_first    <= 1'b1;
      end
      if (r_state == S_SCAN) begin
        r_first <= 1'b0;
        if (!w_last) r_addr <= r_addr + N'(1);
      end
      if (w_cmp_en) begin
        r_min_dist <= w_new_dist;
        r_min_idx  <= w_new_idx;
      end
      if (r_state == S_FLUSH) begin
        r_res_idx  <= w_new_idx;
        r_res_dist <= w_new_dist;
      end
      if (w_handoff) r_pts_done <= r_pts_done + W'(1);
    end
  end

  assign pt_ready  = r_pt_ready;
  assign cent_rd   = (r_state == S_SCAN);
  assign cent_addr = r_addr;
  assign res_valid = r_res_valid;
  assign res_idx   = r_res_idx;
  assign res_dist  = r_res_dist;
  assign pts_done  = r_pts_done;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
